// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: word width,
// fetch state encoding and the {pc, insn} queue entry layout.
package fetch_queue_pkg;

    localparam int WORD_W = 32;

    // RUN: the in-flight word (if any) is live.
    // DRAIN: the in-flight word belongs to a superseded fetch stream.
    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] insn;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Generic synchronous FIFO with occupancy count and a single-cycle flush.
// Push into a full FIFO is only legal together with a pop; callers guard it.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage array: written at the tail on every push.
    // NOTE: the data array is deliberately left out of reset; only the pointers
    // and count decide which entries are meaningful, and the top zeroes its
    // outputs while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues word-addressed fetches to a synchronous
// instruction memory, buffers returned words with their PCs in a FIFO and
// hands them to decode with a valid/ready handshake. Redirects flush the
// queue and squash the word still in flight.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [WORD_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              insn_valid,
    input  logic              insn_ready,
    output logic [WORD_W-1:0] insn,
    output logic [WORD_W-1:0] insn_pc
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = $bits(fq_entry_t);

    typedef logic [CNT_W:0] occ_t;

    fetch_state_t      state;
    logic [WORD_W-1:0] fetch_pc;
    logic [WORD_W-1:0] flight_pc;
    logic              in_flight;

    logic [CNT_W-1:0]  q_count;
    logic              q_empty;
    logic              q_push;
    logic              q_pop;
    fq_entry_t         q_tail;
    fq_entry_t         q_head;
    occ_t              occupancy;

    // Slots already spoken for: queued entries plus a live word on its way back.
    assign occupancy = occ_t'(q_count) + occ_t'(in_flight && (state == RUN));
    assign imem_req  = !rst && (occupancy < occ_t'(DEPTH));
    assign imem_addr = fetch_pc;

    // A redirect discards both the arriving word and the head entry.
    assign q_push = in_flight && (state == RUN) && !redirect_valid;
    assign q_pop  = insn_valid && insn_ready && !redirect_valid;
    assign q_tail = '{pc: flight_pc, insn: imem_rdata};

    sync_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect_valid),
        .push    (q_push),
        .wr_data (q_tail),
        .pop     (q_pop),
        .rd_data (q_head),
        .count   (q_count),
        .empty   (q_empty)
    );

    assign insn_valid = !q_empty;
    assign insn       = q_empty ? '0 : q_head.insn;
    assign insn_pc    = q_empty ? '0 : q_head.pc;

    // Fetch state machine: tracks the fetch PC, the in-flight request and
    // whether that request was superseded by a redirect.
    // NOTE: every register here uses non-blocking assignment so that all of
    // them sample the pre-edge values of one another.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            fetch_pc  <= RESET_PC;
            flight_pc <= '0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= imem_req;
            if (imem_req) begin
                flight_pc <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                state    <= imem_req ? DRAIN : RUN;
            end else begin
                state <= RUN;
                if (imem_req) begin
                    fetch_pc <= fetch_pc + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized
// ready/redirect phase, checked by a scoreboard that knows only that each
// fetch stream delivers consecutive word addresses from its start PC.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        insn_valid;
    logic        insn_ready = 1'b0;
    logic [31:0] insn;
    logic [31:0] insn_pc;

    int vectors    = 0;
    int miscompares = 0;

    // Scoreboard state: start PCs of pending streams, next expected PC,
    // and a log of delivered PCs for directed checks.
    logic [31:0] seg_q[$];
    logic [31:0] delivered[$];
    logic [31:0] exp_pc = RESET_PC;
    logic        hold = 1'b0;
    logic [31:0] held_pc;
    logic [31:0] held_insn;
    int          deliveries = 0;

    fetch_queue #(
        .DEPTH(DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .insn_valid     (insn_valid),
        .insn_ready     (insn_ready),
        .insn           (insn),
        .insn_pc        (insn_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 ^ (a * 32'h9E37_79B9);
    endfunction

    // Instruction memory: synchronous read, garbage when not requested.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every delivered entry against the expected stream.
    always @(negedge clk) begin
        if (rst) begin
            exp_pc = RESET_PC;
            hold   = 1'b0;
        end else begin
            if (hold) begin
                check("stall_valid", 64'(insn_valid), 64'd1);
                check("stall_pc", 64'(insn_pc), 64'(held_pc));
                check("stall_insn", 64'(insn), 64'(held_insn));
            end
            hold      = insn_valid && !insn_ready && !redirect_valid;
            held_pc   = insn_pc;
            held_insn = insn;
            if (insn_valid && insn_ready) begin
                check("deliver_pc", 64'(insn_pc), 64'(exp_pc));
                check("deliver_insn", 64'(insn), 64'(mem_word(exp_pc)));
                delivered.push_back(insn_pc);
                deliveries++;
                exp_pc = exp_pc + 32'd1;
            end
            if (redirect_valid) begin
                check("redirect_pending", 64'(seg_q.size() != 0), 64'd1);
                if (seg_q.size() != 0) begin
                    exp_pc = seg_q.pop_front();
                end
            end
        end
    end

    task automatic do_reset(input logic rdy);
        @(posedge clk); #1;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        insn_ready     = rdy;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        seg_q.push_back(tgt);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        delivered.delete();
    endtask

    task automatic wait_deliv(input int n, input string name);
        int k = 0;
        while (delivered.size() < n && k < 50) begin
            @(posedge clk);
            k++;
        end
        check(name, 64'(delivered.size() >= n), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] tgt;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(insn_valid), 64'd0);
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_insn", 64'(insn), 64'd0);
        check("rst_pc", 64'(insn_pc), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'(RESET_PC));

        // First fetch latency and consecutive delivery.
        do_reset(1'b1);
        @(negedge clk);
        check("c0_valid", 64'(insn_valid), 64'd0);
        check("c0_req", 64'(imem_req), 64'd1);
        check("c0_addr", 64'(imem_addr), 64'(RESET_PC));
        @(negedge clk);
        check("c1_valid", 64'(insn_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("first_valid", 64'(insn_valid), 64'd1);
            check("first_pc", 64'(insn_pc), 64'(i));
            check("first_insn", 64'(insn), 64'(mem_word(32'(i))));
        end
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (insn_valid && insn_ready) n++;
        end
        check("throughput", 64'(n), 64'd20);

        // Decode stall fills exactly DEPTH entries; release drains in order.
        do_reset(1'b0);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req) n++;
        end
        check("stall_fetches", 64'(n), 64'(DEPTH));
        check("stall_req_low", 64'(imem_req), 64'd0);
        check("stall_head_pc", 64'(insn_pc), 64'(RESET_PC));
        check("stall_head_insn", 64'(insn), 64'(mem_word(RESET_PC)));
        @(posedge clk); #1;
        delivered.delete();
        insn_ready = 1'b1;
        wait_deliv(6, "release_progress");
        if (delivered.size() >= 6) begin
            for (int i = 0; i < 6; i++) check("release_order", 64'(delivered[i]), 64'(i));
        end

        // Redirect while the fetch of word 5 is in flight.
        do_reset(1'b1);
        n = 0;
        while (!(imem_req && imem_addr == 32'd5) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("saw_req5", 64'(imem_req && imem_addr == 32'd5), 64'd1);
        redirect_to(32'h20);
        @(negedge clk);
        check("redir_valid_low", 64'(insn_valid), 64'd0);
        check("redir_req", 64'(imem_req), 64'd1);
        check("redir_addr", 64'(imem_addr), 64'h20);
        wait_deliv(1, "redir_progress");
        if (delivered.size() >= 1) check("redir_first_pc", 64'(delivered[0]), 64'h20);

        // Redirect together with a pop of a full queue.
        do_reset(1'b0);
        repeat (10) @(posedge clk);
        #1;
        insn_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        seg_q.push_back(32'h100);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        delivered.delete();
        @(negedge clk);
        check("full_redir_empty", 64'(insn_valid), 64'd0);
        wait_deliv(1, "full_redir_progress");
        if (delivered.size() >= 1) check("full_redir_pc", 64'(delivered[0]), 64'h100);

        // PC wrap.
        redirect_to(32'hFFFF_FFFF);
        wait_deliv(3, "wrap_progress");
        if (delivered.size() >= 3) begin
            check("wrap_pc0", 64'(delivered[0]), 64'hFFFF_FFFF);
            check("wrap_pc1", 64'(delivered[1]), 64'h0);
            check("wrap_pc2", 64'(delivered[2]), 64'h1);
        end

        // Reset pulse with the queue half full.
        do_reset(1'b0);
        repeat (4) @(negedge clk);
        check("half_valid", 64'(insn_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", 64'(insn_valid), 64'd0);
        check("midrst_req", 64'(imem_req), 64'd0);
        @(posedge clk); #1;
        insn_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        delivered.delete();
        @(negedge clk);
        check("restart_req", 64'(imem_req), 64'd1);
        check("restart_addr", 64'(imem_addr), 64'(RESET_PC));
        wait_deliv(1, "restart_progress");
        if (delivered.size() >= 1) check("restart_pc", 64'(delivered[0]), 64'(RESET_PC));

        // Randomized ready stalls and redirects, including back-to-back ones.
        n = deliveries;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            insn_ready = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 6) begin
                case ($urandom_range(0, 3))
                    0:       tgt = $urandom;
                    1:       tgt = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                    default: tgt = 32'($urandom_range(0, 255));
                endcase
                redirect_valid = 1'b1;
                redirect_pc    = tgt;
                seg_q.push_back(tgt);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        insn_ready     = 1'b1;
        repeat (10) @(posedge clk);
        check("rand_progress", 64'(deliveries - n > 100), 64'd1);
        check("redirects_consumed", 64'(seg_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
